// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer initiator: core request/grant/response port to NONSEQ/SINGLE
// transfers, with address/data phase overlap, wait states and two-cycle ERROR replay.
`timescale 1ns/1ps

`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif
`ifndef SIZE_B
`define SIZE_B  3'b000
`endif
`ifndef SIZE_HW
`define SIZE_HW 3'b001
`endif
`ifndef SIZE_W
`define SIZE_W  3'b010
`endif
`ifndef TRANS_IDLE
`define TRANS_IDLE 2'b00
`endif
`ifndef TRANS_NONESEQ
`define TRANS_NONESEQ 2'b10
`endif
`ifndef RESP_OKAY
`define RESP_OKAY  1'b0
`endif
`ifndef RESP_ERROR
`define RESP_ERROR 1'b1
`endif

module ahb_lite_master #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic                      HCLK,
   input  logic                      HRST_N,
   // core side
   input  logic                      req_i,
   input  logic [`AHB_BUS_WIDTH-1:0] req_addr_i,
   input  logic                      req_we_i,
   input  logic [2:0]                req_size_i,
   input  logic [`AHB_BUS_WIDTH-1:0] req_wdata_i,
   output logic                      gnt_o,
   output logic                      rsp_valid_o,
   output logic [`AHB_BUS_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   // AHB side
   output logic [`AHB_BUS_WIDTH-1:0] HADDR_o,
   output logic [1:0]                HTRANS_o,
   output logic [2:0]                HSIZE_o,
   output logic [2:0]                HBURST_o,
   output logic [3:0]                HPROT_o,
   output logic                      HWRITE_o,
   output logic [`AHB_BUS_WIDTH-1:0] HWDATA_o,
   input  logic [`AHB_BUS_WIDTH-1:0] HRDATA_i,
   input  logic                      HREADY_i,
   input  logic                      HRESP_i,
   // debug: 1 while in the second error cycle wait (ERR1)
   output logic                      fsm_state_o
);

   localparam int W = `AHB_BUS_WIDTH;

   // Handshake: a request is taken on any cycle where req_i and gnt_o are both high;
   // the core must hold the request stable until then. rsp_valid_o is a one-cycle
   // pulse with no back-pressure; responses return strictly in request order.

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_ERR1   = 1'b1
   } state_t;

   state_t state_q, state_d;

   // slot A: HADDR_o/HWRITE_o/HSIZE_o hold its address-phase fields directly
   logic         a_valid_q;
   logic [W-1:0] a_wdata_q;
   // slot D
   logic         d_valid_q;
   logic         d_we_q;

   logic         err_state;
   logic         a_adv;
   logic         d_done;
   logic         err_entry;
   logic         a_valid_d;
   logic [1:0]   htrans_d;

   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) state_q <= ST_NORMAL;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      err_state = 1'b0;
      gnt_o     = 1'b0;
      a_adv     = 1'b0;
      d_done    = 1'b0;
      err_entry = 1'b0;
      a_valid_d = a_valid_q;
      htrans_d  = `TRANS_IDLE;

      err_state = (state_q == ST_ERR1);
      gnt_o     = req_i & HRST_N & (!a_valid_q | HREADY_i) & !err_state;
      a_adv     = a_valid_q & HREADY_i & !err_state;
      d_done    = d_valid_q & HREADY_i;
      err_entry = !err_state & d_valid_q & (HRESP_i == `RESP_ERROR) & !HREADY_i;

      if (gnt_o)      a_valid_d = 1'b1;
      else if (a_adv) a_valid_d = 1'b0;

      // IDLE is driven into the second error cycle; a retained slot A is replayed after it
      if (err_entry || (err_state && !HREADY_i)) htrans_d = `TRANS_IDLE;
      else if (a_valid_d)                        htrans_d = `TRANS_NONESEQ;
      else                                       htrans_d = `TRANS_IDLE;

      case (state_q)
         ST_NORMAL: if (err_entry) state_d = ST_ERR1;
         ST_ERR1:   if (HREADY_i)  state_d = ST_NORMAL;
         default:                  state_d = ST_NORMAL;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         a_valid_q <= 1'b0;
         a_wdata_q <= '0;
         HADDR_o   <= '0;
         HWRITE_o  <= 1'b0;
         HSIZE_o   <= 3'b000;
         HTRANS_o  <= `TRANS_IDLE;
      end else begin
         a_valid_q <= a_valid_d;
         HTRANS_o  <= htrans_d;
         if (gnt_o) begin
            HADDR_o   <= req_addr_i;
            HWRITE_o  <= req_we_i;
            HSIZE_o   <= req_size_i;
            a_wdata_q <= req_wdata_i;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         d_valid_q <= 1'b0;
         d_we_q    <= 1'b0;
         HWDATA_o  <= '0;
      end else if (a_adv) begin
         d_valid_q <= 1'b1;
         d_we_q    <= HWRITE_o;
         HWDATA_o  <= a_wdata_q;
      end else if (d_done) begin
         d_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRST_N) begin
      if (!HRST_N) begin
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         rsp_valid_o <= d_done;
         rsp_err_o   <= d_done & (HRESP_i == `RESP_ERROR);
         rsp_rdata_o <= (d_done && !d_we_q) ? HRDATA_i : '0;
      end
   end

   assign HBURST_o    = 3'b000;
   assign HPROT_o     = HPROT_VAL;
   assign fsm_state_o = (state_q == ST_ERR1);

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: zero-wait, wait-state, pipelined, ERROR replay,
// byte access and mid-transfer reset scenarios, with a response scoreboard.
`timescale 1ns/1ps

`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif
`ifndef SIZE_B
`define SIZE_B  3'b000
`endif
`ifndef SIZE_HW
`define SIZE_HW 3'b001
`endif
`ifndef SIZE_W
`define SIZE_W  3'b010
`endif
`ifndef TRANS_IDLE
`define TRANS_IDLE 2'b00
`endif
`ifndef TRANS_NONESEQ
`define TRANS_NONESEQ 2'b10
`endif

module tb_ahb_lite_master;

   localparam int W = `AHB_BUS_WIDTH;

   logic         HCLK;
   logic         HRST_N;
   logic         req_i;
   logic [W-1:0] req_addr_i;
   logic         req_we_i;
   logic [2:0]   req_size_i;
   logic [W-1:0] req_wdata_i;
   logic         gnt_o;
   logic         rsp_valid_o;
   logic [W-1:0] rsp_rdata_o;
   logic         rsp_err_o;
   logic [W-1:0] HADDR_o;
   logic [1:0]   HTRANS_o;
   logic [2:0]   HSIZE_o;
   logic [2:0]   HBURST_o;
   logic [3:0]   HPROT_o;
   logic         HWRITE_o;
   logic [W-1:0] HWDATA_o;
   logic [W-1:0] HRDATA_i;
   logic         HREADY_i;
   logic         HRESP_i;
   logic         fsm_state_o;

   int n_checks = 0;
   int n_pass   = 0;

   // expected responses {err, rdata}, in request order
   logic [W:0] exp_q[$];
   logic [W:0] exp_rsp;

   ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
      .HCLK        (HCLK),
      .HRST_N      (HRST_N),
      .req_i       (req_i),
      .req_addr_i  (req_addr_i),
      .req_we_i    (req_we_i),
      .req_size_i  (req_size_i),
      .req_wdata_i (req_wdata_i),
      .gnt_o       (gnt_o),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .HADDR_o     (HADDR_o),
      .HTRANS_o    (HTRANS_o),
      .HSIZE_o     (HSIZE_o),
      .HBURST_o    (HBURST_o),
      .HPROT_o     (HPROT_o),
      .HWRITE_o    (HWRITE_o),
      .HWDATA_o    (HWDATA_o),
      .HRDATA_i    (HRDATA_i),
      .HREADY_i    (HREADY_i),
      .HRESP_i     (HRESP_i),
      .fsm_state_o (fsm_state_o)
   );

   // clock / reset
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // driver tasks
   task automatic next_cycle();
      @(posedge HCLK);
      #1;
   endtask

   task automatic sample();
      @(negedge HCLK);
   endtask

   task automatic idle_bus();
      req_i       = 1'b0;
      req_addr_i  = '0;
      req_we_i    = 1'b0;
      req_size_i  = `SIZE_W;
      req_wdata_i = '0;
      HREADY_i    = 1'b1;
      HRESP_i     = 1'b0;
      HRDATA_i    = '0;
   endtask

   task automatic set_req(input logic we, input logic [W-1:0] addr, input logic [2:0] size,
                          input logic [W-1:0] wdata);
      req_i       = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_size_i  = size;
      req_wdata_i = wdata;
   endtask

   // scoreboard
   always @(negedge HCLK) begin
      if (rsp_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", rsp_valid_o, 0);
         end else begin
            exp_rsp = exp_q.pop_front();
            check("rsp_err_data", {rsp_err_o, rsp_rdata_o}, exp_rsp);
         end
      end
   end

   initial begin
      HRST_N = 1'b0;
      idle_bus();
      set_req(1'b0, 32'h0, `SIZE_W, 32'h0);
      #2;
      check("rst_htrans", HTRANS_o, `TRANS_IDLE);
      check("rst_haddr", HADDR_o, 0);
      check("rst_hwrite", HWRITE_o, 0);
      check("rst_hsize", HSIZE_o, 0);
      check("rst_hburst", HBURST_o, 0);
      check("rst_hprot", HPROT_o, 4'b0011);
      check("rst_hwdata", HWDATA_o, 0);
      check("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_rdata_o}, 0);
      check("rst_gnt", gnt_o, 0);
      check("rst_fsm", fsm_state_o, 0);
      @(posedge HCLK);
      next_cycle();
      HRST_N = 1'b1;
      idle_bus();
      next_cycle();

      // single zero-wait write
      set_req(1'b1, 32'h10, `SIZE_W, 32'hDEADBEEF);
      sample(); check("t1_gnt", gnt_o, 1);
      next_cycle(); req_i = 1'b0;
      sample();
      check("t1_htrans", HTRANS_o, `TRANS_NONESEQ);
      check("t1_haddr", HADDR_o, 32'h10);
      check("t1_hwrite", HWRITE_o, 1);
      check("t1_hsize", HSIZE_o, `SIZE_W);
      next_cycle();
      exp_q.push_back({1'b0, 32'h0});
      sample();
      check("t1_hwdata", HWDATA_o, 32'hDEADBEEF);
      check("t1_htrans_idle", HTRANS_o, `TRANS_IDLE);
      check("t1_rsp_early", rsp_valid_o, 0);
      next_cycle();
      sample(); check("t1_rsp_t3", rsp_valid_o, 1);
      next_cycle();
      sample(); check("t1_rsp_pulse", rsp_valid_o, 0);
      next_cycle();

      // read with two wait states
      set_req(1'b0, 32'h10, `SIZE_W, 32'h0);
      sample(); check("t2_gnt", gnt_o, 1);
      next_cycle(); req_i = 1'b0;
      sample();
      check("t2_htrans", HTRANS_o, `TRANS_NONESEQ);
      check("t2_haddr", HADDR_o, 32'h10);
      check("t2_hwrite", HWRITE_o, 0);
      next_cycle(); HREADY_i = 1'b0;
      sample();
      check("t2_w1_haddr", HADDR_o, 32'h10);
      check("t2_w1_hwdata", HWDATA_o, 32'h0);
      check("t2_w1_rsp", rsp_valid_o, 0);
      next_cycle();
      sample();
      check("t2_w2_haddr", HADDR_o, 32'h10);
      check("t2_w2_hwdata", HWDATA_o, 32'h0);
      check("t2_w2_rsp", rsp_valid_o, 0);
      next_cycle(); HREADY_i = 1'b1; HRDATA_i = 32'hDEADBEEF;
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      sample(); check("t2_rsp_early", rsp_valid_o, 0);
      next_cycle(); HRDATA_i = '0;
      sample(); check("t2_rsp_t5", rsp_valid_o, 1);
      next_cycle();

      // four back-to-back reads, zero wait
      for (int c = 0; c < 8; c++) begin
         req_i      = (c < 4);
         req_we_i   = 1'b0;
         req_size_i = `SIZE_W;
         req_addr_i = 32'(c * 4);
         if (c >= 2 && c <= 5) begin
            HRDATA_i = 32'hA000_0000 + 32'((c - 2) * 4);
            exp_q.push_back({1'b0, HRDATA_i});
         end else begin
            HRDATA_i = '0;
         end
         sample();
         if (c < 4) check("t3_gnt", gnt_o, 1);
         if (c >= 1 && c <= 4) begin
            check("t3_haddr", HADDR_o, 32'((c - 1) * 4));
            check("t3_htrans", HTRANS_o, `TRANS_NONESEQ);
         end
         if (c == 5) check("t3_htrans_idle", HTRANS_o, `TRANS_IDLE);
         if (c >= 3 && c <= 6) check("t3_rsp_valid", rsp_valid_o, 1);
         if (c == 7) check("t3_rsp_end", rsp_valid_o, 0);
         next_cycle();
      end

      // wait state with a full slot A and a pending request
      set_req(1'b0, 32'h30, `SIZE_W, 32'h0);
      sample(); check("t4_gnt_a", gnt_o, 1);
      next_cycle(); set_req(1'b0, 32'h34, `SIZE_W, 32'h0);
      sample(); check("t4_gnt_b", gnt_o, 1); check("t4_haddr_a", HADDR_o, 32'h30);
      next_cycle(); set_req(1'b0, 32'h38, `SIZE_W, 32'h0); HREADY_i = 1'b0;
      sample();
      check("t4_gnt_wait", gnt_o, 0);
      check("t4_haddr_b", HADDR_o, 32'h34);
      check("t4_htrans_wait", HTRANS_o, `TRANS_NONESEQ);
      next_cycle(); HREADY_i = 1'b1; HRDATA_i = 32'hB000_0030;
      exp_q.push_back({1'b0, 32'hB000_0030});
      sample(); check("t4_gnt_c", gnt_o, 1); check("t4_haddr_hold", HADDR_o, 32'h34);
      next_cycle(); req_i = 1'b0; HRDATA_i = 32'hB000_0034;
      exp_q.push_back({1'b0, 32'hB000_0034});
      sample(); check("t4_haddr_c", HADDR_o, 32'h38); check("t4_rsp_a", rsp_valid_o, 1);
      next_cycle(); HRDATA_i = 32'hB000_0038;
      exp_q.push_back({1'b0, 32'hB000_0038});
      sample(); check("t4_rsp_b", rsp_valid_o, 1); check("t4_htrans_idle", HTRANS_o, `TRANS_IDLE);
      next_cycle(); HRDATA_i = '0;
      sample(); check("t4_rsp_c", rsp_valid_o, 1);
      next_cycle();

      // write with ERROR, following read is replayed
      set_req(1'b1, 32'h40, `SIZE_W, 32'h1234_5678);
      sample(); check("t5_gnt_w", gnt_o, 1);
      next_cycle(); set_req(1'b0, 32'h44, `SIZE_W, 32'h0);
      sample(); check("t5_gnt_r", gnt_o, 1);
      next_cycle(); req_i = 1'b0; HREADY_i = 1'b0; HRESP_i = 1'b1;
      sample();
      check("t5_e1_htrans", HTRANS_o, `TRANS_NONESEQ);
      check("t5_e1_haddr", HADDR_o, 32'h44);
      check("t5_e1_hwdata", HWDATA_o, 32'h1234_5678);
      check("t5_e1_fsm", fsm_state_o, 0);
      next_cycle(); HREADY_i = 1'b1; HRESP_i = 1'b1;
      set_req(1'b0, 32'h50, `SIZE_W, 32'h0);
      exp_q.push_back({1'b1, 32'h0});
      sample();
      check("t5_e2_htrans", HTRANS_o, `TRANS_IDLE);
      check("t5_e2_haddr", HADDR_o, 32'h44);
      check("t5_e2_fsm", fsm_state_o, 1);
      check("t5_e2_gnt", gnt_o, 0);
      next_cycle(); req_i = 1'b0; HRESP_i = 1'b0;
      sample();
      check("t5_err_rsp", {rsp_valid_o, rsp_err_o}, 2'b11);
      check("t5_replay_htrans", HTRANS_o, `TRANS_NONESEQ);
      check("t5_replay_haddr", HADDR_o, 32'h44);
      check("t5_replay_hwrite", HWRITE_o, 0);
      check("t5_fsm_back", fsm_state_o, 0);
      next_cycle(); HRDATA_i = 32'hCAFE_F00D;
      exp_q.push_back({1'b0, 32'hCAFE_F00D});
      sample(); check("t5_htrans_idle", HTRANS_o, `TRANS_IDLE);
      next_cycle(); HRDATA_i = '0;
      sample(); check("t5_read_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
      next_cycle();

      // byte read at an unaligned address
      set_req(1'b0, 32'h3, `SIZE_B, 32'h0);
      sample(); check("t6_gnt", gnt_o, 1);
      next_cycle(); req_i = 1'b0;
      sample(); check("t6_haddr", HADDR_o, 32'h3); check("t6_hsize", HSIZE_o, `SIZE_B);
      next_cycle(); HRDATA_i = 32'h1122_3344;
      exp_q.push_back({1'b0, 32'h1122_3344});
      sample();
      next_cycle(); HRDATA_i = '0;
      sample(); check("t6_rsp", rsp_valid_o, 1);
      next_cycle();

      // reset during a data-phase wait
      set_req(1'b0, 32'h60, `SIZE_W, 32'h5555_AAAA);
      sample(); check("t7_gnt", gnt_o, 1);
      next_cycle(); req_i = 1'b0;
      sample(); check("t7_haddr", HADDR_o, 32'h60);
      next_cycle(); HREADY_i = 1'b0;
      sample(); check("t7_hwdata_pre", HWDATA_o, 32'h5555_AAAA);
      #1; HRST_N = 1'b0; req_i = 1'b1;
      #1;
      check("t7_rst_htrans", HTRANS_o, `TRANS_IDLE);
      check("t7_rst_haddr", HADDR_o, 0);
      check("t7_rst_hwdata", HWDATA_o, 0);
      check("t7_rst_gnt", gnt_o, 0);
      next_cycle();
      next_cycle();
      HRST_N = 1'b1; idle_bus();
      for (int c = 0; c < 3; c++) begin
         sample(); check("t7_no_rsp", rsp_valid_o, 0);
         next_cycle();
      end
      set_req(1'b1, 32'h70, `SIZE_W, 32'h0BAD_F00D);
      sample(); check("t7_gnt_after", gnt_o, 1);
      next_cycle(); req_i = 1'b0;
      sample(); check("t7_htrans_after", HTRANS_o, `TRANS_NONESEQ);
      next_cycle();
      exp_q.push_back({1'b0, 32'h0});
      sample(); check("t7_hwdata_after", HWDATA_o, 32'h0BAD_F00D);
      next_cycle();
      sample(); check("t7_rsp_after", rsp_valid_o, 1);
      next_cycle();

      repeat (2) next_cycle();
      check("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
